// File: rtl/ysyx_22041752_mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, access-size codes, load FSM states.
package ysyx_22041752_mem_stage_pkg;

  localparam int PC_WD     = 64;
  localparam int DATA_WD   = 64;
  localparam int ES_MS_WD  = 2 + 2 + 1 + 1 + 5 + DATA_WD + PC_WD;
  localparam int MS_WS_WD  = 1 + 5 + DATA_WD + PC_WD;
  localparam int MS_FWD_WD = 71;

  localparam logic [1:0] MB_BYTE  = 2'b00;
  localparam logic [1:0] MB_HALF  = 2'b01;
  localparam logic [1:0] MB_WORD  = 2'b10;
  localparam logic [1:0] MB_DWORD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } ms_state_e;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] mem_bytes, input logic [2:0] off);
    case (mem_bytes)
      MB_HALF:  is_misaligned = off[0];
      MB_WORD:  is_misaligned = |off[1:0];
      MB_DWORD: is_misaligned = |off;
      default:  is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041752_mem_stage_load_ext.sv
// Load data alignment: shifts the addressed bytes of a doubleword down to bit 0
// and sign- or zero-extends them to the selected access width.
module ysyx_22041752_load_ext
  import ysyx_22041752_mem_stage_pkg::*;
(
  input  logic [DATA_WD-1:0] i_data,
  input  logic [2:0]         i_off,
  input  logic [1:0]         i_mem_bytes,
  input  logic               i_sext,
  input  logic               i_zext,
  output logic [DATA_WD-1:0] o_result
);

  logic [DATA_WD-1:0] w_raw;
  logic               w_sign;

  // With neither extension flag set the shifted doubleword passes straight through.
  always_comb begin
    w_raw    = i_data >> {i_off, 3'b000};
    w_sign   = 1'b0;
    o_result = w_raw;
    if (i_sext || i_zext) begin
      case (i_mem_bytes)
        MB_BYTE: begin
          w_sign   = i_sext & w_raw[7];
          o_result = {{56{w_sign}}, w_raw[7:0]};
        end
        MB_HALF: begin
          w_sign   = i_sext & w_raw[15];
          o_result = {{48{w_sign}}, w_raw[15:0]};
        end
        MB_WORD: begin
          w_sign   = i_sext & w_raw[31];
          o_result = {{32{w_sign}}, w_raw[31:0]};
        end
        default: o_result = w_raw;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22041752_mem_stage.sv
// Memory-access pipeline stage: holds the execute bus, waits for load data, forwards to decode.
// Optional misalignment flag enabled by defining YSYX_22041752_MS_MISALIGN_CHECK_EN.
module ysyx_22041752_mem_stage
  import ysyx_22041752_mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ws_allowin,
  output logic                 ms_allowin,
  input  logic                 es_to_ms_valid,
  input  logic [ES_MS_WD-1:0]  es_to_ms_bus,
  input  logic                 data_sram_rvalid,
  input  logic [DATA_WD-1:0]   data_sram_rdata,
  output logic                 ms_to_ws_valid,
  output logic [MS_WS_WD-1:0]  ms_to_ws_bus,
  output logic [MS_FWD_WD-1:0] ms_forward_bus,
  output logic                 ms_misalign,
  output logic [PC_WD-1:0]     debug_ms_pc
);

  logic                r_ms_valid;
  logic [ES_MS_WD-1:0] r_es_bus;
  logic [DATA_WD-1:0]  r_ld_buf;
  ms_state_e           r_state;
  ms_state_e           w_state_next;

  logic                w_res_sext;
  logic                w_res_zext;
  logic [1:0]          w_mem_bytes;
  logic                w_mem_re;
  logic                w_rf_we;
  logic [4:0]          w_rd;
  logic [DATA_WD-1:0]  w_alu_result;
  logic [PC_WD-1:0]    w_pc;

  logic                w_es_mem_re;
  logic                w_ready_go;
  logic                w_rdata_hit;
  logic                w_load_pending;
  logic [DATA_WD-1:0]  w_ld_data;
  logic [DATA_WD-1:0]  w_ld_result;
  logic [DATA_WD-1:0]  w_final_result;

  assign {w_res_sext, w_res_zext, w_mem_bytes, w_mem_re, w_rf_we, w_rd, w_alu_result, w_pc} = r_es_bus;
  assign w_es_mem_re = es_to_ms_bus[PC_WD + DATA_WD + 6];

  // Read data only counts while a load is actually waiting for it.
  assign w_rdata_hit    = r_ms_valid & w_mem_re & (r_state == S_WAIT) & data_sram_rvalid;
  assign w_ready_go     = !w_mem_re | ((r_state == S_WAIT) & data_sram_rvalid) | (r_state == S_DONE);
  assign ms_allowin     = !r_ms_valid | (w_ready_go & ws_allowin);
  assign ms_to_ws_valid = r_ms_valid & w_ready_go;
  assign w_load_pending = r_ms_valid & w_mem_re & !w_ready_go;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ms_valid <= 1'b0;
      r_es_bus   <= '0;
      r_ld_buf   <= '0;
      r_state    <= S_IDLE;
    end else begin
      r_state <= w_state_next;
      if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        r_es_bus <= es_to_ms_bus;
      end
      if (w_rdata_hit) begin
        r_ld_buf <= data_sram_rdata;
      end
    end
  end

  // Whenever the stage accepts, the state restarts for whatever enters: WAIT for a load, IDLE otherwise.
  always_comb begin
    w_state_next = r_state;
    if (ms_allowin) begin
      w_state_next = (es_to_ms_valid && w_es_mem_re) ? S_WAIT : S_IDLE;
    end else begin
      case (r_state)
        S_WAIT:  if (w_rdata_hit) w_state_next = S_DONE;
        S_DONE:  w_state_next = S_DONE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign w_ld_data = (r_state == S_DONE) ? r_ld_buf : data_sram_rdata;

  ysyx_22041752_load_ext u_load_ext (
    .i_data      (w_ld_data),
    .i_off       (w_alu_result[2:0]),
    .i_mem_bytes (w_mem_bytes),
    .i_sext      (w_res_sext),
    .i_zext      (w_res_zext),
    .o_result    (w_ld_result)
  );

  always_comb begin
    if (w_mem_re) begin
      w_final_result = w_ld_result;
    end else if (w_res_sext) begin
      w_final_result = {{32{w_alu_result[31]}}, w_alu_result[31:0]};
    end else begin
      w_final_result = w_alu_result;
    end
  end

  assign ms_to_ws_bus   = {w_rf_we, w_rd, w_final_result, w_pc};
  assign ms_forward_bus = {w_load_pending, r_ms_valid & w_rf_we, w_final_result, w_rd};
  assign debug_ms_pc    = w_pc;

`ifdef YSYX_22041752_MS_MISALIGN_CHECK_EN
  assign ms_misalign = r_ms_valid & w_mem_re & is_misaligned(w_mem_bytes, w_alu_result[2:0]);
`else
  assign ms_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22041752_mem_stage.sv
// Directed testbench for ysyx_22041752_mem_stage: ALU pass-through, load latency,
// DONE hold, back-to-back loads, reset mid-wait and the misalignment flag.
module tb_ysyx_22041752_mem_stage;

  logic         clk;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [138:0] es_to_ms_bus;
  logic         data_sram_rvalid;
  logic [63:0]  data_sram_rdata;
  logic         ms_to_ws_valid;
  logic [133:0] ms_to_ws_bus;
  logic [70:0]  ms_forward_bus;
  logic         ms_misalign;
  logic [63:0]  debug_ms_pc;

  int testsRun  = 0;
  int failCount = 0;

`ifdef YSYX_22041752_MS_MISALIGN_CHECK_EN
  localparam logic EXP_MISALIGN = 1'b1;
`else
  localparam logic EXP_MISALIGN = 1'b0;
`endif

  ysyx_22041752_mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ws_allowin       (ws_allowin),
    .ms_allowin       (ms_allowin),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .data_sram_rvalid (data_sram_rvalid),
    .data_sram_rdata  (data_sram_rdata),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .ms_forward_bus   (ms_forward_bus),
    .ms_misalign      (ms_misalign),
    .debug_ms_pc      (debug_ms_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [138:0] makeBus(input logic sext, input logic zext, input logic [1:0] mb,
                                           input logic re, input logic we, input logic [4:0] rd,
                                           input logic [63:0] alu, input logic [63:0] pc);
    return {sext, zext, mb, re, we, rd, alu, pc};
  endfunction

  // Drive all stage inputs for the current cycle.
  task automatic applyStimulus(input logic esValid, input logic [138:0] bus, input logic rvalid,
                               input logic [63:0] rdata, input logic wsAllow);
    es_to_ms_valid   = esValid;
    es_to_ms_bus     = bus;
    data_sram_rvalid = rvalid;
    data_sram_rdata  = rdata;
    ws_allowin       = wsAllow;
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  logic [138:0] busA;
  logic [138:0] busB;

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    #2;
    checkOutput("rst_ws_valid", ms_to_ws_valid, 0);
    checkOutput("rst_allowin", ms_allowin, 1);
    checkOutput("rst_fwd_bits", ms_forward_bus[70:69], 0);
    checkOutput("rst_misalign", ms_misalign, 0);
    checkOutput("rst_pc", debug_ms_pc, 0);
    #10;
    reset = 1'b1;

    // ALU result passes through with no extra latency
    nextCycle();
    applyStimulus(1'b1, makeBus(0, 0, 2'b00, 0, 1, 5'd5, 64'h1234, 64'h8000_0000), 1'b0, '0, 1'b1);
    #1;
    checkOutput("alu_allowin_in", ms_allowin, 1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("alu_ws_valid", ms_to_ws_valid, 1);
    checkOutput("alu_result", ms_to_ws_bus[127:64], 64'h1234);
    checkOutput("alu_rd_we", {ms_to_ws_bus[133:128]}, {1'b1, 5'd5});
    checkOutput("alu_allowin", ms_allowin, 1);
    checkOutput("alu_fwd_valid", ms_forward_bus[69], 1);
    checkOutput("alu_pending", ms_forward_bus[70], 0);
    checkOutput("alu_pc", debug_ms_pc, 64'h8000_0000);

    // 32-bit op result sign-extended
    nextCycle();
    applyStimulus(1'b1, makeBus(1, 0, 2'b00, 0, 1, 5'd6, 64'h0000_0000_8000_0001, 64'h8000_0004), 1'b0, '0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("sext32_result", ms_to_ws_bus[127:64], 64'hFFFF_FFFF_8000_0001);

    // lb at offset 3, data returns after three waiting cycles
    nextCycle();
    applyStimulus(1'b1, makeBus(1, 0, 2'b00, 1, 1, 5'd7, 64'h8000_1003, 64'h8000_0008), 1'b0, '0, 1'b1);
    #1;
    checkOutput("lb_enter_allowin", ms_allowin, 1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
      #1;
      checkOutput($sformatf("lb_pending%0d", i), ms_forward_bus[70], 1);
      checkOutput($sformatf("lb_wait_valid%0d", i), ms_to_ws_valid, 0);
      checkOutput($sformatf("lb_wait_allowin%0d", i), ms_allowin, 0);
    end
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1, 64'h0000_0000_8000_0000, 1'b1);
    #1;
    checkOutput("lb_valid", ms_to_ws_valid, 1);
    checkOutput("lb_result", ms_to_ws_bus[127:64], 64'hFFFF_FFFF_FFFF_FF80);
    checkOutput("lb_fwd_result", ms_forward_bus[68:5], 64'hFFFF_FFFF_FFFF_FF80);
    checkOutput("lb_pending_clr", ms_forward_bus[70], 0);
    checkOutput("lb_misalign", ms_misalign, 0);

    // Spurious rvalid with the stage empty
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1, 64'h1111_2222_3333_4444, 1'b1);
    #1;
    checkOutput("idle_spur_valid", ms_to_ws_valid, 0);
    checkOutput("idle_spur_allowin", ms_allowin, 1);

    // lhu at offset 6 with write-back stalled: result held from the buffer
    nextCycle();
    applyStimulus(1'b1, makeBus(0, 1, 2'b01, 1, 1, 5'd9, 64'h8000_2006, 64'h8000_000C), 1'b0, '0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1, 64'hBEEF_0000_0000_0000, 1'b0);
    #1;
    checkOutput("lhu_rv_valid", ms_to_ws_valid, 1);
    checkOutput("lhu_rv_result", ms_to_ws_bus[127:64], 64'hBEEF);
    checkOutput("lhu_rv_allowin", ms_allowin, 0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    #1;
    checkOutput("lhu_done1_valid", ms_to_ws_valid, 1);
    checkOutput("lhu_done1_result", ms_to_ws_bus[127:64], 64'hBEEF);
    checkOutput("lhu_done1_allowin", ms_allowin, 0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1, 64'h1111_1111_1111_1111, 1'b0);
    #1;
    checkOutput("lhu_done2_result", ms_to_ws_bus[127:64], 64'hBEEF);
    checkOutput("lhu_done2_pending", ms_forward_bus[70], 0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("lhu_release_result", ms_to_ws_bus[127:64], 64'hBEEF);
    checkOutput("lhu_release_allowin", ms_allowin, 1);
    nextCycle();
    #1;
    checkOutput("lhu_after_valid", ms_to_ws_valid, 0);

    // Back-to-back loads: lw (sext, off 4) then lbu (zext, off 1)
    busA = makeBus(1, 0, 2'b10, 1, 1, 5'd10, 64'h8000_3004, 64'h8000_0010);
    busB = makeBus(0, 1, 2'b00, 1, 1, 5'd11, 64'h8000_4001, 64'h8000_0014);
    applyStimulus(1'b1, busA, 1'b0, '0, 1'b1);
    nextCycle();
    applyStimulus(1'b1, busB, 1'b1, 64'h8765_4321_0000_0000, 1'b1);
    #1;
    checkOutput("b2b_a_valid", ms_to_ws_valid, 1);
    checkOutput("b2b_a_result", ms_to_ws_bus[127:64], 64'hFFFF_FFFF_8765_4321);
    checkOutput("b2b_a_allowin", ms_allowin, 1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1, 64'h0000_0000_0000_AB00, 1'b1);
    #1;
    checkOutput("b2b_b_valid", ms_to_ws_valid, 1);
    checkOutput("b2b_b_result", ms_to_ws_bus[127:64], 64'hAB);
    checkOutput("b2b_b_pc", debug_ms_pc, 64'h8000_0014);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("b2b_drain_valid", ms_to_ws_valid, 0);

    // Reset while waiting for load data; the late rvalid must be ignored
    applyStimulus(1'b1, makeBus(1, 0, 2'b11, 1, 1, 5'd12, 64'h8000_5000, 64'h8000_0018), 1'b0, '0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("rstw_pending", ms_forward_bus[70], 1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rstw_valid", ms_to_ws_valid, 0);
    checkOutput("rstw_allowin", ms_allowin, 1);
    checkOutput("rstw_fwd_bits", ms_forward_bus[70:69], 0);
    checkOutput("rstw_pc", debug_ms_pc, 0);
    #1;
    reset = 1'b1;
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1, 64'h5555_6666_7777_8888, 1'b1);
    #1;
    checkOutput("rstw_late_valid", ms_to_ws_valid, 0);
    checkOutput("rstw_late_allowin", ms_allowin, 1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("rstw_after_valid", ms_to_ws_valid, 0);
    checkOutput("rstw_after_pending", ms_forward_bus[70], 0);

    // Misaligned lw at offset 2: flag depends on build, result still produced
    applyStimulus(1'b1, makeBus(1, 0, 2'b10, 1, 1, 5'd13, 64'h8000_6002, 64'h8000_001C), 1'b0, '0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("mis_flag_wait", ms_misalign, EXP_MISALIGN);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1, 64'h0000_CAFE_BABE_0000, 1'b1);
    #1;
    checkOutput("mis_flag_rv", ms_misalign, EXP_MISALIGN);
    checkOutput("mis_result", ms_to_ws_bus[127:64], 64'hFFFF_FFFF_CAFE_BABE);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("mis_flag_empty", ms_misalign, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/ysyx_22041752_mem_stage.md
Name: ysyx_22041752_mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage and upstream of write-back.
- Registers the execute-stage bus. For loads, waits a variable number of cycles for the data-SRAM read response, then aligns and sign/zero-extends the data.
- Drives the write-back bus and a forwarding bus to decode.
- Uses the same valid/allowin handshake as the rest of the pipeline.

Parameters:
- PC_WD, 64, program-counter width
- DATA_WD, 64, register/data width
- ES_MS_WD, 2+2+1+1+5+DATA_WD+PC_WD (=139), width of es_to_ms_bus
- MS_WS_WD, 1+5+DATA_WD+PC_WD (=134), width of ms_to_ws_bus

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ws_allowin  in  1  write-back stage can accept
- ms_allowin  out  1  this stage can accept
- es_to_ms_valid  in  1  execute bus valid
- es_to_ms_bus  in  ES_MS_WD  {res_sext, res_zext, mem_bytes[1:0], mem_re, rf_we, rd[4:0], alu_result, pc}; alu_result is the effective address for loads
- data_sram_rvalid  in  1  read-data return strobe, one pulse per issued read
- data_sram_rdata  in  DATA_WD  aligned 8-byte doubleword containing the address
- ms_to_ws_valid  out  1  write-back bus valid
- ms_to_ws_bus  out  MS_WS_WD  {rf_we, rd, final_result, pc}
- ms_forward_bus  out  71  {ms_load_pending, ms_forward_valid, final_result, rd}
- ms_misalign  out  1  misaligned-access flag (see Optional Feature)
- debug_ms_pc  out  PC_WD  pc of the instruction held

Behaviour:
- Reset (reset=0, async):
  - ms_valid=0, state=IDLE, bus register=0, load buffer=0.
  - Outputs: ms_to_ws_valid=0, ms_allowin=1, forward valid bits=0, ms_misalign=0.
- Handshake:
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - On ms_allowin, ms_valid <= es_to_ms_valid.
  - Bus register loads only when es_to_ms_valid & ms_allowin.
  - ms_to_ws_valid = ms_valid & ms_ready_go.
- Non-load (mem_re=0): ms_ready_go=1; zero extra latency; final_result=alu_result.
- Load FSM (state advances only while ms_valid & mem_re):
  - IDLE -> WAIT when a load enters the stage.
  - WAIT: on data_sram_rvalid, capture rdata into the load buffer.
    - If ws_allowin is high in the same cycle, hand off and go to IDLE, or directly to WAIT if a new load enters.
    - Otherwise go to DONE.
  - DONE: hold the buffer until ws_allowin, then go to IDLE/WAIT as above.
  - ms_ready_go = !mem_re | (state==WAIT & rvalid) | state==DONE.
  - Same-cycle result selects rdata combinationally; DONE uses the buffer.
- Alignment and extension:
  - off = alu_result[2:0]; raw = data >> (off*8).
  - mem_bytes: 00 = byte, 01 = half, 10 = word, 11 = dword.
  - res_sext: sign-extend from the selected width. res_zext: zero-extend. Neither: dword passed through.
  - res_sext on a non-load (32-bit ops): sign-extend alu_result[31:0].
- Spurious rvalid in IDLE/DONE or with ms_valid=0 is ignored; no state change.
- Reset mid-WAIT: the transaction is dropped; a later rvalid is ignored per the rule above.
- Forwarding:
  - ms_forward_valid = ms_valid & rf_we.
  - ms_load_pending = ms_valid & mem_re & !ms_ready_go; decode must stall on a match.
- debug_ms_pc = registered pc.

Optional Feature:
- Macro: YSYX_22041752_MS_MISALIGN_CHECK_EN
- Defined: ms_misalign = ms_valid & mem_re & (address not naturally aligned for mem_bytes: half off[0], word off[1:0], dword off[2:0]). Result is still produced.
- Undefined: ms_misalign tied to 0; no check logic.

Decomposition:
- Shared header: bus widths ES_MS_WD, MS_WS_WD, MS_FWD_WD=71, mem_bytes encodings, FSM state encodings (IDLE=0, WAIT=1, DONE=2).
- One sub-module: ysyx_22041752_load_ext (combinational align + extend: data, off, mem_bytes, sext, zext -> result).

Test Plan:
- ALU op: alu_result=0x1234, rf_we=1, ws_allowin=1 -> ms_to_ws_valid the next cycle, final_result=0x1234; ms_allowin stays 1.
- lb, addr=0x...03, rdata=0x0000_0000_8000_0000 returned 3 cycles later -> ms_load_pending=1 for 3 cycles, then final_result=0xFFFF_FFFF_FFFF_FF80.
- lhu, addr=0x...06, rdata=0xBEEF_0000_0000_0000, ws_allowin=0 on the rvalid cycle -> DONE; held 2 cycles; then final_result=0xBEEF.
- Back-to-back loads, rvalid the cycle after each issue, ws_allowin=1 -> WAIT->WAIT with no bubble; two correct results in consecutive cycles.
- Reset asserted while in WAIT, then rvalid pulse after release -> outputs 0, state IDLE, pulse ignored.
- With the macro defined, lw at addr 0x...02 -> ms_misalign=1; without the macro -> ms_misalign=0.
